// File: rtl/xbar_switch_matrix.sv
// ---------------------------------------------------------------------------
// xbar_switch_matrix
//   2x2 crossbar datapath that sits behind the crossbar control FSM.
//   load/inaddr/outaddr fill a shadow routing table (one entry per slave).
//   cnfg commits the pending entries of idle slaves into the active routes.
//   Each committed route carries exactly one transaction from its master to
//   its slave. On completion the per-slave release pulse (ack1/ack2) goes
//   back to the control block.
//
// Ports
//   clk, reset         : clock, asynchronous active-low reset
//   load, cnfg         : shadow-capture / commit strobes from control
//   inaddr, outaddr    : master / slave index, sampled while load=1
//   ack1, ack2         : one-cycle release pulse for slave 0 / slave 1
//   mN_*  (N=0,1)      : master side (req/sel/we/addr/wdata in;
//                        rdata/ack/err out)
//   sK_*  (K=0,1)      : slave side (req/we/addr/wdata out; rdata/ack in)
//
// Optional feature macro: XBAR_TIMEOUT_EN
//   When defined, each slave has a BUSY-cycle counter. A slave that stays
//   BUSY for TIMEOUT cycles without acknowledging is force-completed:
//   rdata is 0 and mN_err pulses. When undefined, BUSY waits indefinitely
//   and mN_err is tied to 0.
// ---------------------------------------------------------------------------
module xbar_switch_matrix #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              cnfg,
    input  logic              inaddr,
    input  logic              outaddr,
    output logic              ack1,
    output logic              ack2,
    input  logic              m0_req,
    input  logic              m0_sel,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_ack,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic              m1_sel,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_ack,
    output logic              m1_err,
    output logic              s0_req,
    output logic              s0_we,
    output logic [ADDR_W-1:0] s0_addr,
    output logic [DATA_W-1:0] s0_wdata,
    input  logic [DATA_W-1:0] s0_rdata,
    input  logic              s0_ack,
    output logic              s1_req,
    output logic              s1_we,
    output logic [ADDR_W-1:0] s1_addr,
    output logic [DATA_W-1:0] s1_wdata,
    input  logic [DATA_W-1:0] s1_rdata,
    input  logic              s1_ack
);

    typedef enum logic [1:0] {ST_IDLE, ST_ROUTED, ST_BUSY, ST_DONE} slv_state_t;

    // Masters and slaves are gathered into arrays so the per-slave logic can be
    // written once and indexed by the route's source.
    logic [1:0]        m_req, m_sel, m_we;
    logic [ADDR_W-1:0] m_addr  [2];
    logic [DATA_W-1:0] m_wdata [2];
    logic [DATA_W-1:0] s_rdata [2];
    logic [1:0]        s_ack;

    assign m_req      = {m1_req, m0_req};
    assign m_sel      = {m1_sel, m0_sel};
    assign m_we       = {m1_we,  m0_we};
    assign m_addr[0]  = m0_addr;
    assign m_addr[1]  = m1_addr;
    assign m_wdata[0] = m0_wdata;
    assign m_wdata[1] = m1_wdata;
    assign s_rdata[0] = s0_rdata;
    assign s_rdata[1] = s1_rdata;
    assign s_ack      = {s1_ack, s0_ack};

    // Per-slave results, gathered back for the master-side OR and slave ports
    logic [1:0]        commit_k, done_k, busy_k, src_k, err_k, we_k;
    logic [DATA_W-1:0] cap_k   [2];
    logic [ADDR_W-1:0] addr_k  [2];
    logic [DATA_W-1:0] wdata_k [2];

    // Shadow table. Commit clears the entries it consumes. A load in the same
    // cycle is written afterwards, so it wins and stays pending.
    logic [1:0] sh_src_q, sh_vld_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh_src_q <= '0;
            sh_vld_q <= '0;
        end else begin
            sh_vld_q <= sh_vld_q & ~commit_k;
            if (load) begin
                sh_src_q[outaddr] <= inaddr;
                sh_vld_q[outaddr] <= 1'b1;
            end
        end
    end

    for (genvar k = 0; k < 2; k++) begin : g_slave
        slv_state_t        st_q, st_d;
        logic              src_q, hold_we_q, fire, to_hit;
        logic [ADDR_W-1:0] hold_addr_q;
        logic [DATA_W-1:0] hold_wdata_q, cap_q;

        assign commit_k[k] = cnfg && sh_vld_q[k] && (st_q == ST_IDLE);
        // Forward only a request from the routed master that targets this slave
        assign fire = (st_q == ST_ROUTED) && m_req[src_q] && (m_sel[src_q] == 1'(k));

`ifdef XBAR_TIMEOUT_EN
        localparam int CNT_W = $clog2(TIMEOUT + 1);
        logic [CNT_W-1:0] cnt_q;
        logic             err_q;

        // cnt_q holds the number of BUSY cycles already elapsed before the current one
        assign to_hit = (st_q == ST_BUSY) && !s_ack[k] && (cnt_q == CNT_W'(TIMEOUT - 1));

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                cnt_q <= '0;
                err_q <= 1'b0;
            end else begin
                if (fire)
                    cnt_q <= '0;
                else if (st_q == ST_BUSY)
                    cnt_q <= cnt_q + 1'b1;
                if (st_q == ST_BUSY)
                    err_q <= to_hit;
            end
        end
        assign err_k[k] = err_q;
`else
        logic unused_timeout;
        assign unused_timeout = (TIMEOUT == 0);
        assign to_hit   = 1'b0;
        assign err_k[k] = 1'b0;
`endif

        always_comb begin
            st_d = st_q;
            case (st_q)
                ST_IDLE:   if (commit_k[k]) st_d = ST_ROUTED;
                ST_ROUTED: if (fire)        st_d = ST_BUSY;
                ST_BUSY:   if (s_ack[k] || to_hit) st_d = ST_DONE;
                ST_DONE:   st_d = ST_IDLE;
                default:   st_d = ST_IDLE;
            endcase
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset)
                st_q <= ST_IDLE;
            else
                st_q <= st_d;
        end

        // Route, slave-side holding registers and captured read data
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                src_q        <= 1'b0;
                hold_we_q    <= 1'b0;
                hold_addr_q  <= '0;
                hold_wdata_q <= '0;
                cap_q        <= '0;
            end else begin
                if (commit_k[k])
                    src_q <= sh_src_q[k];
                if (fire) begin
                    hold_we_q    <= m_we[src_q];
                    hold_addr_q  <= m_addr[src_q];
                    hold_wdata_q <= m_wdata[src_q];
                end
                if (st_q == ST_BUSY && s_ack[k])
                    cap_q <= s_rdata[k];
                else if (to_hit)
                    cap_q <= '0;
            end
        end

        assign done_k[k]  = (st_q == ST_DONE);
        assign busy_k[k]  = (st_q == ST_BUSY);
        assign src_k[k]   = src_q;
        assign cap_k[k]   = cap_q;
        assign we_k[k]    = hold_we_q;
        assign addr_k[k]  = hold_addr_q;
        assign wdata_k[k] = hold_wdata_q;
    end

    // Master responses: OR over DONE slaves routed from that master
    logic [1:0]        m_ack_v, m_err_v;
    logic [DATA_W-1:0] m_rd_v [2];

    always_comb begin
        m_ack_v   = '0;
        m_err_v   = '0;
        m_rd_v[0] = '0;
        m_rd_v[1] = '0;
        for (int k = 0; k < 2; k++) begin
            if (done_k[k]) begin
                m_ack_v[src_k[k]] = 1'b1;
                m_err_v[src_k[k]] = m_err_v[src_k[k]] | err_k[k];
                m_rd_v[src_k[k]]  = m_rd_v[src_k[k]] | cap_k[k];
            end
        end
    end

    assign m0_ack   = m_ack_v[0];
    assign m1_ack   = m_ack_v[1];
    assign m0_err   = m_err_v[0];
    assign m1_err   = m_err_v[1];
    assign m0_rdata = m_rd_v[0];
    assign m1_rdata = m_rd_v[1];
    assign ack1     = done_k[0];
    assign ack2     = done_k[1];

    assign s0_req   = busy_k[0];
    assign s1_req   = busy_k[1];
    assign s0_we    = we_k[0];
    assign s1_we    = we_k[1];
    assign s0_addr  = addr_k[0];
    assign s1_addr  = addr_k[1];
    assign s0_wdata = wdata_k[0];
    assign s1_wdata = wdata_k[1];

endmodule

// File: tb/tb_xbar_switch_matrix.sv
// ---------------------------------------------------------------------------
// tb_xbar_switch_matrix
//   Directed bench for xbar_switch_matrix (default build, no timeout).
//   Inputs change 1 time unit after the rising edge; outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_xbar_switch_matrix;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              load, cnfg, inaddr, outaddr;
    logic              ack1, ack2;
    logic              m0_req, m0_sel, m0_we, m0_ack, m0_err;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata, m0_rdata;
    logic              m1_req, m1_sel, m1_we, m1_ack, m1_err;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata, m1_rdata;
    logic              s0_req, s0_we, s0_ack;
    logic [ADDR_W-1:0] s0_addr;
    logic [DATA_W-1:0] s0_wdata, s0_rdata;
    logic              s1_req, s1_we, s1_ack;
    logic [ADDR_W-1:0] s1_addr;
    logic [DATA_W-1:0] s1_wdata, s1_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    xbar_switch_matrix #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(255)) dut (
        .clk(clk), .reset(reset), .load(load), .cnfg(cnfg),
        .inaddr(inaddr), .outaddr(outaddr), .ack1(ack1), .ack2(ack2),
        .m0_req(m0_req), .m0_sel(m0_sel), .m0_we(m0_we), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_req(m1_req), .m1_sel(m1_sel), .m1_we(m1_we), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
        .s0_req(s0_req), .s0_we(s0_we), .s0_addr(s0_addr), .s0_wdata(s0_wdata),
        .s0_rdata(s0_rdata), .s0_ack(s0_ack),
        .s1_req(s1_req), .s1_we(s1_we), .s1_addr(s1_addr), .s1_wdata(s1_wdata),
        .s1_rdata(s1_rdata), .s1_ack(s1_ack)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One load cycle followed by one commit cycle
    task automatic route(input logic src, input logic dst);
        load = 1'b1; inaddr = src; outaddr = dst;
        tick();
        load = 1'b0; inaddr = 1'bz; outaddr = 1'bz; cnfg = 1'b1;
        tick();
        cnfg = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        load = 1'b0; cnfg = 1'b0; inaddr = 1'b0; outaddr = 1'b0;
        m0_req = 1'b0; m0_sel = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_sel = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
        s0_ack = 1'b0; s0_rdata = '0; s1_ack = 1'b0; s1_rdata = '0;

        // ---- reset state
        #3;
        chk("rst_s0_req", 64'(s0_req), 64'(0));
        chk("rst_s1_req", 64'(s1_req), 64'(0));
        chk("rst_acks",   64'({ack1, ack2, m0_ack, m1_ack, m0_err, m1_err}), 64'(0));
        chk("rst_m0_rdata", 64'(m0_rdata), 64'(0));
        #9 reset = 1'b1;
        tick();

        // ---- single write m0 -> s1
        route(1'b0, 1'b1);
        m0_req = 1'b1; m0_sel = 1'b1; m0_we = 1'b1; m0_addr = 16'h0010; m0_wdata = 32'hA5A5A5A5;
        chk("t1_s1_req_pre", 64'(s1_req), 64'(0));
        tick();
        chk("t1_s1_req",   64'(s1_req),   64'(1));
        chk("t1_s1_we",    64'(s1_we),    64'(1));
        chk("t1_s1_addr",  64'(s1_addr),  64'(16'h0010));
        chk("t1_s1_wdata", 64'(s1_wdata), 64'(32'hA5A5A5A5));
        chk("t1_s0_req",   64'(s0_req),   64'(0));
        tick(); tick();
        chk("t1_s1_hold", 64'({s1_req, s1_addr}), 64'({1'b1, 16'h0010}));
        s1_ack = 1'b1; s1_rdata = 32'h0000_00C3;
        chk("t1_m0_ack_early", 64'(m0_ack), 64'(0));
        tick();
        s1_ack = 1'b0; s1_rdata = '0;
        chk("t1_m0_ack",   64'(m0_ack),   64'(1));
        chk("t1_ack2",     64'(ack2),     64'(1));
        chk("t1_ack1",     64'(ack1),     64'(0));
        chk("t1_m0_rdata", 64'(m0_rdata), 64'(32'h0000_00C3));
        chk("t1_m0_err",   64'(m0_err),   64'(0));
        m0_req = 1'b0; m0_we = 1'b0;
        tick();
        chk("t1_after", 64'({m0_ack, ack2, s1_req}), 64'(0));

        // ---- two routes, simultaneous reads
        load = 1'b1; inaddr = 1'b0; outaddr = 1'b0;
        tick();
        inaddr = 1'b1; outaddr = 1'b1;
        tick();
        load = 1'b0; cnfg = 1'b1;
        tick();
        cnfg = 1'b0;
        m0_req = 1'b1; m0_sel = 1'b0; m0_addr = 16'h0020;
        m1_req = 1'b1; m1_sel = 1'b1; m1_addr = 16'h0030;
        tick();
        chk("t2_s0", 64'({s0_req, s0_we, s0_addr}), 64'({1'b1, 1'b0, 16'h0020}));
        chk("t2_s1", 64'({s1_req, s1_we, s1_addr}), 64'({1'b1, 1'b0, 16'h0030}));
        s0_ack = 1'b1; s0_rdata = 32'h11; s1_ack = 1'b1; s1_rdata = 32'h22;
        tick();
        s0_ack = 1'b0; s1_ack = 1'b0;
        chk("t2_m0_rdata", 64'(m0_rdata), 64'(32'h11));
        chk("t2_m1_rdata", 64'(m1_rdata), 64'(32'h22));
        chk("t2_acks", 64'({m0_ack, m1_ack, ack1, ack2}), 64'(4'b1111));
        m0_req = 1'b0; m1_req = 1'b0;
        tick();

        // ---- unrouted master request is not forwarded
        route(1'b0, 1'b0);
        m1_req = 1'b1; m1_sel = 1'b0; m1_addr = 16'h0044;
        tick(); tick();
        chk("t3_s0_req_m1", 64'(s0_req), 64'(0));
        chk("t3_m1_ack",    64'(m1_ack), 64'(0));
        m0_req = 1'b1; m0_sel = 1'b0; m0_addr = 16'h0040;
        tick();
        chk("t3_s0_m0", 64'({s0_req, s0_addr}), 64'({1'b1, 16'h0040}));
        s0_ack = 1'b1; s0_rdata = 32'h33;
        tick();
        s0_ack = 1'b0;
        chk("t3_m_acks", 64'({m0_ack, m1_ack, m0_rdata}), 64'({1'b1, 1'b0, 32'h33}));
        m0_req = 1'b0;
        tick(); tick();
        chk("t3_idle", 64'({s0_req, m1_ack, ack1}), 64'(0));
        m1_req = 1'b0;

        // ---- cnfg while busy: shadow retained, applied on next cnfg
        route(1'b0, 1'b0);
        m0_req = 1'b1; m0_sel = 1'b0; m0_addr = 16'h0050;
        tick();
        route(1'b1, 1'b0);
        m1_req = 1'b1; m1_sel = 1'b0; m1_addr = 16'h0060;
        tick();
        chk("t4_busy_hold", 64'({s0_req, s0_addr}), 64'({1'b1, 16'h0050}));
        s0_ack = 1'b1; s0_rdata = 32'h55;
        tick();
        s0_ack = 1'b0;
        chk("t4_done", 64'({m0_ack, m1_ack, ack1}), 64'(3'b101));
        m0_req = 1'b0;
        tick();
        tick();
        chk("t4_wait_cnfg", 64'(s0_req), 64'(0));
        cnfg = 1'b1;
        tick();
        cnfg = 1'b0;
        chk("t4_routed", 64'(s0_req), 64'(0));
        tick();
        chk("t4_s0_m1", 64'({s0_req, s0_addr}), 64'({1'b1, 16'h0060}));
        s0_ack = 1'b1; s0_rdata = 32'h77;
        tick();
        s0_ack = 1'b0;
        chk("t4_m1", 64'({m1_ack, m0_ack, ack1, m1_rdata}), 64'({3'b101, 32'h77}));
        m1_req = 1'b0;
        tick();

        // ---- async reset in the middle of BUSY
        route(1'b1, 1'b1);
        m1_req = 1'b1; m1_sel = 1'b1; m1_addr = 16'h0099; m1_we = 1'b1;
        tick();
        chk("t5_busy", 64'(s1_req), 64'(1));
        #2 reset = 1'b0;
        #1;
        chk("t5_rst_outs", 64'({s1_req, s1_we, s1_addr, ack1, ack2, m1_ack}), 64'(0));
        m1_req = 1'b0; m1_we = 1'b0;
        #3 reset = 1'b1;
        s1_ack = 1'b1; s1_rdata = 32'hEE;
        tick();
        s1_ack = 1'b0;
        tick();
        chk("t5_no_ack", 64'({ack1, ack2, m1_ack, s1_req}), 64'(0));
        tick();
        chk("t5_idle", 64'({ack2, s1_req}), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
